// File: rtl/vx_tcu_fedp_feeder_if.sv
// Bundle of request, response and FEDP-side signals used by the FEDP feeder.
// The slave modport is the feeder's own view of the bundle.
// The master modport is the view of the surrounding logic (requester plus FEDP).
interface vx_tcu_fedp_feeder_if #(
  parameter int N         = 4,
  parameter int K_STEPS   = 4,
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8
);
  logic                      req_valid;
  logic                      req_ready;
  logic [3:0]                req_fmt_s;
  logic [3:0]                req_fmt_d;
  logic [K_STEPS*N*XLEN-1:0] req_a;
  logic [K_STEPS*N*XLEN-1:0] req_b;
  logic [XLEN-1:0]           req_c;
  logic [TAG_WIDTH-1:0]      req_tag;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [XLEN-1:0]           rsp_data;
  logic [TAG_WIDTH-1:0]      rsp_tag;

  logic                      busy;

  logic                      fedp_enable;
  logic [3:0]                fedp_fmt_s;
  logic [3:0]                fedp_fmt_d;
  logic [N*XLEN-1:0]         fedp_a_row;
  logic [N*XLEN-1:0]         fedp_b_col;
  logic [XLEN-1:0]           fedp_c_val;
  logic [XLEN-1:0]           fedp_d_val;

  modport slave (
    input  req_valid, req_fmt_s, req_fmt_d, req_a, req_b, req_c, req_tag,
    input  rsp_ready, fedp_d_val,
    output req_ready, rsp_valid, rsp_data, rsp_tag, busy,
    output fedp_enable, fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val
  );

  modport master (
    output req_valid, req_fmt_s, req_fmt_d, req_a, req_b, req_c, req_tag,
    output rsp_ready, fedp_d_val,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, busy,
    input  fedp_enable, fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val
  );
endinterface

// File: rtl/vx_tcu_fedp_feeder.sv
// Sequencer in front of a single FEDP dot-product unit.
// It splits one request into K_STEPS chunks and chains each partial result back in as the next addend.
// It does no arithmetic of its own; the accumulator is carried as raw bits, so NaN-boxed values pass through untouched.
module vx_tcu_fedp_feeder #(
  parameter int N         = 4,
  parameter int K_STEPS   = 4,
  parameter int LATENCY   = 4,
  parameter int TAG_WIDTH = 8,
  parameter int XLEN      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  vx_tcu_fedp_feeder_if.slave     bus
);

  localparam int CHUNK_W = N * XLEN;
  localparam int KW      = (K_STEPS > 1) ? $clog2(K_STEPS) : 1;
  localparam int CW      = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [KW-1:0] LAST_K = KW'(K_STEPS - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LATENCY);
  localparam logic [CW-1:0] WAIT_LAST = CW'(1);

  if (K_STEPS < 1) begin : g_kStepsCheck
    $error("K_STEPS must be at least 1");
  end

  logic [1:0]                  r_state;
  logic [KW-1:0]               r_k;
  logic [CW-1:0]               r_waitCnt;
  logic [XLEN-1:0]             r_acc;
  logic [TAG_WIDTH-1:0]        r_tag;
  logic [K_STEPS*CHUNK_W-1:0]  r_a;
  logic [K_STEPS*CHUNK_W-1:0]  r_b;
  logic [3:0]                  r_fmtS;
  logic [3:0]                  r_fmtD;

  logic w_reqReady;
  logic w_reqFire;
  logic w_lastStep;

  assign w_reqReady = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.rsp_ready);
  assign w_reqFire  = bus.req_valid & w_reqReady;
  assign w_lastStep = (r_k == LAST_K);

  // Operand and format capture; these have no reset because they are only read after an accept.
  always_ff @(posedge clk) begin
    if (w_reqFire) begin
      r_a    <= bus.req_a;
      r_b    <= bus.req_b;
      r_fmtS <= bus.req_fmt_s;
      r_fmtD <= bus.req_fmt_d;
    end
  end

  // Sequencing FSM: one ISSUE cycle per chunk, then LATENCY WAIT cycles before the result is chained back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_waitCnt <= '0;
      r_acc     <= '0;
      r_tag     <= '0;
    end else if (w_reqFire) begin
      r_state <= S_ISSUE;
      r_k     <= '0;
      r_acc   <= bus.req_c;
      r_tag   <= bus.req_tag;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (LATENCY == 0) begin
            r_acc <= bus.fedp_d_val;
            if (w_lastStep) begin
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end else begin
            r_waitCnt <= WAIT_LOAD;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_waitCnt <= r_waitCnt - 1'b1;
          if (r_waitCnt == WAIT_LAST) begin
            r_acc <= bus.fedp_d_val;
            if (w_lastStep) begin
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = w_reqReady;
  assign bus.rsp_valid   = (r_state == S_DONE);
  assign bus.rsp_data    = r_acc;
  assign bus.rsp_tag     = r_tag;
  assign bus.busy        = (r_state != S_IDLE);

  assign bus.fedp_enable = (r_state == S_ISSUE) | (r_state == S_WAIT);
  assign bus.fedp_fmt_s  = r_fmtS;
  assign bus.fedp_fmt_d  = r_fmtD;
  assign bus.fedp_a_row  = r_a[r_k * CHUNK_W +: CHUNK_W];
  assign bus.fedp_b_col  = r_b[r_k * CHUNK_W +: CHUNK_W];
  assign bus.fedp_c_val  = r_acc;

endmodule

// File: tb/tb_vx_tcu_fedp_feeder.sv
// Self-checking bench for the FEDP feeder.
// Two instances are built: the default LATENCY=4 one and a LATENCY=0 one driving a combinational FEDP model.
module tb_vx_tcu_fedp_feeder;

  localparam int N    = 4;
  localparam int K    = 4;
  localparam int LAT  = 4;
  localparam int TW   = 8;
  localparam int XLEN = 32;
  localparam int CHW  = N * XLEN;
  localparam int AW   = K * N * XLEN;

  logic clk = 1'b0;
  logic reset;

  int checkCnt = 0;
  int passCnt  = 0;

  always #5 clk = ~clk;

  vx_tcu_fedp_feeder_if #(.N(N), .K_STEPS(K), .XLEN(XLEN), .TAG_WIDTH(TW)) bus ();
  vx_tcu_fedp_feeder_if #(.N(N), .K_STEPS(K), .XLEN(XLEN), .TAG_WIDTH(TW)) bus0 ();

  vx_tcu_fedp_feeder #(.N(N), .K_STEPS(K), .LATENCY(LAT), .TAG_WIDTH(TW), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vx_tcu_fedp_feeder #(.N(N), .K_STEPS(K), .LATENCY(0), .TAG_WIDTH(TW), .XLEN(XLEN)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  // Real-number helpers for the fp16 path of the FEDP stand-in (normal numbers only).
  function automatic real h2r(input logic [15:0] h);
    logic [63:0] d;
    if (h[14:10] == 5'd0) return 0.0;
    d = {h[15], 11'(int'(h[14:10]) - 15 + 1023), h[9:0], 42'b0};
    return $bitstoreal(d);
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  // Stand-in for one FEDP evaluation: fmt 0001 is fp16 into fp32, anything else is int8 into int32.
  function automatic logic [31:0] fedpModel(input logic [3:0] fmt, input logic [CHW-1:0] a,
                                            input logic [CHW-1:0] b, input logic [31:0] c);
    if (fmt == 4'b0001) begin
      real acc = f2r(c);
      for (int i = 0; i < 2 * N; i++) acc = acc + h2r(a[16*i +: 16]) * h2r(b[16*i +: 16]);
      return r2f(acc);
    end else begin
      int s = int'(c);
      for (int i = 0; i < 4 * N; i++) begin
        int pa = $signed(a[8*i +: 8]);
        int pb = $signed(b[8*i +: 8]);
        s = s + pa * pb;
      end
      return s;
    end
  endfunction

  // Expected int8 result for a whole request: the addend plus every byte product across all chunks.
  function automatic logic [31:0] refInt8(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [31:0] c);
    int s = int'(c);
    for (int i = 0; i < AW / 8; i++) begin
      int pa = $signed(a[8*i +: 8]);
      int pb = $signed(b[8*i +: 8]);
      s = s + pa * pb;
    end
    return s;
  endfunction

  // FEDP pipeline model with LAT enabled-cycle latency.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (bus.fedp_enable) begin
      pipe[0] <= fedpModel(bus.fedp_fmt_s, bus.fedp_a_row, bus.fedp_b_col, bus.fedp_c_val);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.fedp_d_val  = pipe[LAT-1];
  assign bus0.fedp_d_val = fedpModel(bus0.fedp_fmt_s, bus0.fedp_a_row, bus0.fedp_b_col, bus0.fedp_c_val);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one request at a falling edge, confirms it is accepted, and returns at the falling edge of cycle 1.
  task automatic applyStimulus(input logic [3:0] fmtS, input logic [3:0] fmtD, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input logic [31:0] c, input logic [TW-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_fmt_s = fmtS;
    bus.req_fmt_d = fmtD;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_c     = c;
    bus.req_tag   = tag;
    checkOutput("req_ready at accept", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Counts cycles from cycle 1 until rsp_valid, with a bounded budget.
  task automatic waitRsp(output int cyc);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic logic [AW-1:0] randOperand();
    logic [AW-1:0] v;
    for (int i = 0; i < AW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  logic [AW-1:0] onesA, twosB, halfA, halfB, ra, rb;
  logic [31:0]   rc;
  logic [TW-1:0] rtag;
  logic [3:0]    rfmtD;
  int            cyc;
  int            enCnt;
  int            delay;
  logic          sawValid;

  initial begin
    onesA = {64{8'h01}};
    twosB = {64{8'h02}};
    halfA = {32{16'h3C00}};
    halfB = {32{16'h4000}};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_fmt_s = '0; bus.req_fmt_d = '0;
    bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_tag = '0; bus.rsp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_fmt_s = '0; bus0.req_fmt_d = '0;
    bus0.req_a = '0; bus0.req_b = '0; bus0.req_c = '0; bus0.req_tag = '0; bus0.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("reset busy", 64'(bus.busy), 64'd0);
    checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset fedp_enable", 64'(bus.fedp_enable), 64'd0);
    checkOutput("reset rsp_data", 64'(bus.rsp_data), 64'd0);
    checkOutput("reset rsp_tag", 64'(bus.rsp_tag), 64'd0);
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // Scenario 1: int8, chained addend visible at each ISSUE cycle
    $display("[TB] int8 default request");
    applyStimulus(4'b1001, 4'b0011, onesA, twosB, 32'd5, 8'h3A);
    checkOutput("fedp_fmt_s", 64'(bus.fedp_fmt_s), 64'h9);
    checkOutput("fedp_fmt_d", 64'(bus.fedp_fmt_d), 64'h3);
    cyc = 1;
    sawValid = 1'b0;
    while (cyc < 21) begin
      if ((cyc - 1) % (LAT + 1) == 0) begin
        checkOutput($sformatf("c_val at cycle %0d", cyc), 64'(bus.fedp_c_val), 64'(5 + 32 * ((cyc - 1) / (LAT + 1))));
        checkOutput($sformatf("enable at cycle %0d", cyc), 64'(bus.fedp_enable), 64'd1);
      end
      if (bus.rsp_valid) sawValid = 1'b1;
      @(negedge clk);
      cyc++;
    end
    checkOutput("early rsp_valid", 64'(sawValid), 64'd0);
    checkOutput("rsp_valid cycle 21", 64'(bus.rsp_valid), 64'd1);
    checkOutput("int8 rsp_data", 64'(bus.rsp_data), 64'd133);
    checkOutput("int8 rsp_tag", 64'(bus.rsp_tag), 64'h3A);
    @(negedge clk);
    checkOutput("idle after retire", 64'(bus.busy), 64'd0);

    // Scenario 2: fp16 products accumulated in fp32
    $display("[TB] fp16 request");
    applyStimulus(4'b0001, 4'b0000, halfA, halfB, 32'h3F800000, 8'h11);
    waitRsp(cyc);
    checkOutput("fp16 latency", 64'(cyc), 64'd21);
    checkOutput("fp16 rsp_data", 64'(bus.rsp_data), 64'h42820000);
    @(negedge clk);

    // Scenario 3: response backpressure for three cycles
    $display("[TB] backpressure");
    bus.rsp_ready = 1'b0;
    applyStimulus(4'b1001, 4'b0000, onesA, twosB, 32'd5, 8'h3A);
    waitRsp(cyc);
    checkOutput("bp latency", 64'(cyc), 64'd21);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp rsp_valid held", 64'(bus.rsp_valid), 64'd1);
      checkOutput("bp rsp_data held", 64'(bus.rsp_data), 64'd133);
      checkOutput("bp rsp_tag held", 64'(bus.rsp_tag), 64'h3A);
      checkOutput("bp fedp_enable", 64'(bus.fedp_enable), 64'd0);
      checkOutput("bp req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    checkOutput("bp rsp_valid 4th", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("bp req_ready on release", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    checkOutput("bp retired", 64'(bus.rsp_valid), 64'd0);

    // Scenario 4: back-to-back request accepted in DONE
    $display("[TB] back-to-back");
    applyStimulus(4'b1001, 4'b0000, onesA, twosB, 32'd5, 8'h3A);
    waitRsp(cyc);
    checkOutput("b2b first latency", 64'(cyc), 64'd21);
    ra = randOperand(); rb = randOperand(); rc = $urandom;
    applyStimulus(4'b1001, 4'b0000, ra, rb, rc, 8'h3B);
    checkOutput("b2b issue enable", 64'(bus.fedp_enable), 64'd1);
    checkOutput("b2b no stale rsp", 64'(bus.rsp_valid), 64'd0);
    checkOutput("b2b c_val", 64'(bus.fedp_c_val), 64'(rc));
    waitRsp(cyc);
    checkOutput("b2b second latency", 64'(cyc), 64'd21);
    checkOutput("b2b rsp_data", 64'(bus.rsp_data), 64'(refInt8(ra, rb, rc)));
    checkOutput("b2b rsp_tag", 64'(bus.rsp_tag), 64'h3B);
    @(negedge clk);

    // Scenario 5: reset in the middle of a request
    $display("[TB] reset mid-operation");
    applyStimulus(4'b1001, 4'b0000, onesA, twosB, 32'd5, 8'h3A);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset busy", 64'(bus.busy), 64'd0);
    checkOutput("mid reset enable", 64'(bus.fedp_enable), 64'd0);
    checkOutput("mid reset rsp_data", 64'(bus.rsp_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post reset busy", 64'(bus.busy), 64'd0);
    checkOutput("post reset req_ready", 64'(bus.req_ready), 64'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.rsp_valid) sawValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("aborted rsp_valid", 64'(sawValid), 64'd0);
    ra = randOperand(); rb = randOperand(); rc = $urandom;
    applyStimulus(4'b1001, 4'b0000, ra, rb, rc, 8'h5C);
    waitRsp(cyc);
    checkOutput("after reset latency", 64'(cyc), 64'd21);
    checkOutput("after reset rsp_data", 64'(bus.rsp_data), 64'(refInt8(ra, rb, rc)));
    checkOutput("after reset rsp_tag", 64'(bus.rsp_tag), 64'h5C);
    @(negedge clk);

    // Randomized int8 requests with random response backpressure
    $display("[TB] random requests");
    for (int t = 0; t < 6; t++) begin
      ra = randOperand(); rb = randOperand(); rc = $urandom;
      rtag = 8'($urandom); rfmtD = 4'($urandom);
      delay = $urandom_range(0, 3);
      bus.rsp_ready = (delay == 0);
      applyStimulus(4'b1001, rfmtD, ra, rb, rc, rtag);
      checkOutput("rand fmt_d", 64'(bus.fedp_fmt_d), 64'(rfmtD));
      waitRsp(cyc);
      checkOutput("rand latency", 64'(cyc), 64'd21);
      checkOutput("rand rsp_data", 64'(bus.rsp_data), 64'(refInt8(ra, rb, rc)));
      checkOutput("rand rsp_tag", 64'(bus.rsp_tag), 64'(rtag));
      for (int d = 0; d < delay; d++) begin
        @(negedge clk);
        checkOutput("rand held data", 64'(bus.rsp_data), 64'(refInt8(ra, rb, rc)));
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("rand retired", 64'(bus.rsp_valid), 64'd0);
    end

    // Scenario 6: LATENCY=0 instance with a combinational FEDP
    $display("[TB] LATENCY=0 instance");
    bus0.req_valid = 1'b1;
    bus0.req_fmt_s = 4'b1001;
    bus0.req_a     = onesA;
    bus0.req_b     = twosB;
    bus0.req_c     = 32'd5;
    bus0.req_tag   = 8'h3A;
    checkOutput("l0 req_ready", 64'(bus0.req_ready), 64'd1);
    @(negedge clk);
    bus0.req_valid = 1'b0;
    cyc = 1;
    enCnt = 0;
    while (!bus0.rsp_valid && cyc < 50) begin
      if (bus0.fedp_enable) enCnt++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("l0 latency", 64'(cyc), 64'd5);
    checkOutput("l0 enable cycles", 64'(enCnt), 64'(K));
    checkOutput("l0 rsp_data", 64'(bus0.rsp_data), 64'd133);
    checkOutput("l0 rsp_tag", 64'(bus0.rsp_tag), 64'h3A);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  // Overall time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish before it", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
